// File: rtl/ndp_stream_ctrl_if.sv
// AXI4-Stream bundle used for the NDP controller ingest and result ports.
// master drives data/valid/last; slave drives ready.
interface ndp_stream_ctrl_if #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ndp_stream_ctrl.sv
// NDP datapath sequencer: AXIS ingest into ping-pong scratch-pad rows, row hand-off to the engine,
// layer chaining via on-chip feedback, and result streaming. Optional ReLU stage: NDP_STREAM_RELU_EN.
module ndp_stream_ctrl #(
    parameter int unsigned  AXIS_W    = 32,
    parameter int unsigned  ELEM_W    = 16,
    parameter int unsigned  ROW_BEATS = 34,
    parameter int unsigned  ACT_BEATS = 2,
    parameter int unsigned  RES_ELEMS = 256,
    localparam int unsigned ADDR_W    = $clog2(ROW_BEATS),
    localparam int unsigned RES_W     = RES_ELEMS * ELEM_W
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              cfg_start,
    input  logic              cfg_relu,
    input  logic              cfg_last,
    output logic              busy,
    output logic              err_short_row,
    ndp_stream_ctrl_if.slave  s_axis,
    output logic              sp_wen,
    output logic              sp_wbank,
    output logic [ADDR_W-1:0] sp_waddr,
    output logic [AXIS_W-1:0] sp_wdata,
    output logic              eng_clear,
    output logic              eng_row_valid,
    output logic              eng_row_bank,
    output logic              eng_row_last,
    input  logic              eng_row_ack,
    input  logic              eng_done,
    input  logic [RES_W-1:0]  eng_result,
    output logic              fb_valid,
    output logic [RES_W-1:0]  fb_data,
    ndp_stream_ctrl_if.master m_axis
);
    localparam int unsigned N_BEATS = RES_W / AXIS_W;
    localparam int unsigned BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_SEND} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d, err_q, err_d, last_q, last_d;
    logic                wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]          full_q, full_d, rlast_q, rlast_d;
    logic                tready_q, tready_d, clear_q, clear_d;
    logic                rvalid_q, rvalid_d, elast_q, elast_d;
    logic                fb_valid_q, fb_valid_d;
    logic [RES_W-1:0]    fb_data_q, fb_data_d, out_q, out_d, result;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                wr_hs, row_end, rd_ack;
    logic [ADDR_W-1:0]   row_base;

`ifdef NDP_STREAM_RELU_EN
    logic                relu_q, relu_d;
    logic [ELEM_W-1:0]   relu_elem;

    // Negative elements (including -0) are forced to +0.
    always_comb begin
        result    = eng_result;
        relu_elem = '0;
        if (relu_q) begin
            for (int unsigned i = 0; i < RES_ELEMS; i++) begin
                relu_elem = eng_result[i*ELEM_W +: ELEM_W];
                if (relu_elem[ELEM_W-1]) result[i*ELEM_W +: ELEM_W] = '0;
            end
        end
    end
`else
    logic unused_cfg_relu;
    assign unused_cfg_relu = cfg_relu;
    assign result          = eng_result;
`endif

    // In feedback mode the activation words are already on chip, so rows start past them.
    assign row_base = fb_valid_q ? ADDR_W'(ACT_BEATS) : '0;
    assign wr_hs    = (state_q == ST_LOAD) && tready_q && s_axis.tvalid;
    assign row_end  = wr_hs && (s_axis.tlast || (waddr_q == ADDR_W'(ROW_BEATS - 1)));
    assign rd_ack   = eng_row_ack && rvalid_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = err_q;
        last_d     = last_q;
`ifdef NDP_STREAM_RELU_EN
        relu_d     = relu_q;
`endif
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        waddr_d    = waddr_q;
        full_d     = full_q;
        rlast_d    = rlast_q;
        clear_d    = 1'b0;
        fb_valid_d = fb_valid_q;
        fb_data_d  = fb_data_q;
        out_d      = out_q;
        beat_d     = beat_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;

        // Reader clears first so a writer set on the other bank in the same cycle survives.
        if (rd_ack) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    last_d  = cfg_last;
`ifdef NDP_STREAM_RELU_EN
                    relu_d  = cfg_relu;
`endif
                    clear_d = 1'b1;
                    waddr_d = row_base;
                end
            end
            ST_LOAD: begin
                if (wr_hs) waddr_d = waddr_q + ADDR_W'(1);
                if (row_end) begin
                    full_d[wbank_q]  = 1'b1;
                    rlast_d[wbank_q] = s_axis.tlast;
                    wbank_d          = ~wbank_q;
                    waddr_d          = row_base;
                    if (s_axis.tlast) begin
                        state_d = ST_DRAIN;
                        if (waddr_q != ADDR_W'(ROW_BEATS - 1)) err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (eng_done) begin
                    if (last_q) begin
                        out_d      = result;
                        fb_valid_d = 1'b0;
                        state_d    = ST_SEND;
                    end else begin
                        fb_data_d  = result;
                        fb_valid_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_SEND: begin
                // Low word first; the out register shifts down one word per accepted beat.
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tlast_d  = (beat_q == BEAT_W'(N_BEATS - 1));
                end else if (m_axis.tready) begin
                    out_d   = out_q >> AXIS_W;
                    beat_d  = beat_q + BEAT_W'(1);
                    tlast_d = (beat_d == BEAT_W'(N_BEATS - 1));
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        beat_d   = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tready_d = (state_d == ST_LOAD) && !row_end && !full_d[wbank_d];
        rvalid_d = full_d[rbank_d];
        elast_d  = rlast_d[rbank_d];
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
`ifdef NDP_STREAM_RELU_EN
            relu_q     <= 1'b0;
`endif
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            waddr_q    <= '0;
            full_q     <= '0;
            rlast_q    <= '0;
            tready_q   <= 1'b0;
            clear_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            elast_q    <= 1'b0;
            fb_valid_q <= 1'b0;
            fb_data_q  <= '0;
            out_q      <= '0;
            beat_q     <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            last_q     <= last_d;
`ifdef NDP_STREAM_RELU_EN
            relu_q     <= relu_d;
`endif
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            waddr_q    <= waddr_d;
            full_q     <= full_d;
            rlast_q    <= rlast_d;
            tready_q   <= tready_d;
            clear_q    <= clear_d;
            rvalid_q   <= rvalid_d;
            elast_q    <= elast_d;
            fb_valid_q <= fb_valid_d;
            fb_data_q  <= fb_data_d;
            out_q      <= out_d;
            beat_q     <= beat_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign busy          = busy_q;
    assign err_short_row = err_q;
    assign s_axis.tready = tready_q;
    assign sp_wen        = wr_hs;
    assign sp_wbank      = wbank_q;
    assign sp_waddr      = waddr_q;
    assign sp_wdata      = s_axis.tdata;
    assign eng_clear     = clear_q;
    assign eng_row_valid = rvalid_q;
    assign eng_row_bank  = rbank_q;
    assign eng_row_last  = elast_q;
    assign fb_valid      = fb_valid_q;
    assign fb_data       = fb_data_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = out_q[AXIS_W-1:0];
endmodule

// File: tb/tb_ndp_stream_ctrl.sv
// Directed bench for ndp_stream_ctrl: scratch-pad writes and result beats are checked against
// scoreboard queues filled when the stimulus is driven.
`timescale 1ns/1ps
module tb_ndp_stream_ctrl;
    localparam int unsigned AXIS_W    = 32;
    localparam int unsigned ELEM_W    = 16;
    localparam int unsigned RES_ELEMS = 256;
    localparam int unsigned RES_W     = RES_ELEMS * ELEM_W;
    localparam int unsigned N_BEATS   = RES_W / AXIS_W;

    logic             axi_aclk    = 1'b0;
    logic             axi_aresetn = 1'b0;
    logic             cfg_start = 1'b0, cfg_relu = 1'b0, cfg_last = 1'b0;
    logic             busy, err_short_row;
    logic             sp_wen, sp_wbank;
    logic [5:0]       sp_waddr;
    logic [31:0]      sp_wdata;
    logic             eng_clear, eng_row_valid, eng_row_bank, eng_row_last;
    logic             eng_row_ack = 1'b0, eng_done = 1'b0;
    logic [RES_W-1:0] eng_result = '0;
    logic             fb_valid;
    logic [RES_W-1:0] fb_data;

    ndp_stream_ctrl_if #(.W(AXIS_W)) s_axis ();
    ndp_stream_ctrl_if #(.W(AXIS_W)) m_axis ();

    ndp_stream_ctrl dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .cfg_start     (cfg_start),
        .cfg_relu      (cfg_relu),
        .cfg_last      (cfg_last),
        .busy          (busy),
        .err_short_row (err_short_row),
        .s_axis        (s_axis),
        .sp_wen        (sp_wen),
        .sp_wbank      (sp_wbank),
        .sp_waddr      (sp_waddr),
        .sp_wdata      (sp_wdata),
        .eng_clear     (eng_clear),
        .eng_row_valid (eng_row_valid),
        .eng_row_bank  (eng_row_bank),
        .eng_row_last  (eng_row_last),
        .eng_row_ack   (eng_row_ack),
        .eng_done      (eng_done),
        .eng_result    (eng_result),
        .fb_valid      (fb_valid),
        .fb_data       (fb_data),
        .m_axis        (m_axis)
    );

    always #5 axi_aclk = ~axi_aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [38:0] sp_exp_q[$];
    logic [32:0] m_exp_q[$];
    bit          tb_wbank = 1'b0;
    bit          tb_rbank = 1'b0;
    logic [38:0] sp_e;
    logic [32:0] m_e;
    bit          stalled = 1'b0;
    logic [32:0] held;
    logic [RES_W-1:0] res1, res3, exp3, res_a, res_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] make_res(input int seed, input bit neg);
        logic [RES_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(RES_ELEMS); i++)
            r[i*ELEM_W +: ELEM_W] = {neg && i[0], 15'(i * 37 + seed)};
        return r;
    endfunction

    // Scratch-pad write and result-stream scoreboards, plus hold-while-stalled check.
    always @(negedge axi_aclk) begin
        if (axi_aresetn) begin
            if (sp_wen) begin
                chk("sp_write_expected", 64'(sp_exp_q.size() != 0), 64'd1);
                if (sp_exp_q.size() != 0) begin
                    sp_e = sp_exp_q.pop_front();
                    chk("sp_write", 64'({sp_wbank, sp_waddr, sp_wdata}), 64'(sp_e));
                end
            end
            if (stalled)
                chk("m_stall_hold", 64'({m_axis.tvalid, m_axis.tlast, m_axis.tdata}), 64'({1'b1, held}));
            if (m_axis.tvalid && m_axis.tready) begin
                chk("m_beat_expected", 64'(m_exp_q.size() != 0), 64'd1);
                if (m_exp_q.size() != 0) begin
                    m_e = m_exp_q.pop_front();
                    chk("m_beat", 64'({m_axis.tlast, m_axis.tdata}), 64'(m_e));
                end
            end
            stalled = m_axis.tvalid && !m_axis.tready;
            held    = {m_axis.tlast, m_axis.tdata};
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_beat(input logic [31:0] d, input logic l, input logic [5:0] addr);
        int n;
        s_axis.tdata  = d;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        sp_exp_q.push_back({tb_wbank, addr, d});
        n = 0;
        do begin
            @(negedge axi_aclk);
            n++;
        end while (!s_axis.tready && n < 200);
        chk("s_tready_wait", 64'(s_axis.tready), 64'd1);
        @(posedge axi_aclk); #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic send_row(input int nbeats, input int start, input bit last_row, input int seed);
        for (int i = 0; i < nbeats; i++)
            push_beat({16'(seed), 16'(i)}, last_row && (i == nbeats - 1), 6'(start + i));
        tb_wbank = ~tb_wbank;
    endtask

    task automatic start_layer(input logic relu, input logic last);
        @(posedge axi_aclk); #1;
        cfg_start = 1'b1; cfg_relu = relu; cfg_last = last;
        @(posedge axi_aclk); #1;
        cfg_start = 1'b0;
        chk("busy_on_start", 64'(busy), 64'd1);
        chk("eng_clear_pulse", 64'(eng_clear), 64'd1);
        chk("err_cleared_on_start", 64'(err_short_row), 64'd0);
        @(posedge axi_aclk); #1;
        chk("eng_clear_one_cycle", 64'(eng_clear), 64'd0);
    endtask

    task automatic ack_row(input logic exp_last);
        int n;
        n = 0;
        while (!eng_row_valid && n < 200) begin
            @(posedge axi_aclk); #1;
            n++;
        end
        chk("row_valid", 64'(eng_row_valid), 64'd1);
        chk("row_bank", 64'(eng_row_bank), 64'(tb_rbank));
        chk("row_last", 64'(eng_row_last), 64'(exp_last));
        eng_row_ack = 1'b1;
        @(posedge axi_aclk); #1;
        eng_row_ack = 1'b0;
        tb_rbank = ~tb_rbank;
    endtask

    task automatic layer_done(input logic [RES_W-1:0] res, input logic [RES_W-1:0] exp, input bit last);
        if (last)
            for (int k = 0; k < int'(N_BEATS); k++)
                m_exp_q.push_back({k == int'(N_BEATS) - 1, exp[k*AXIS_W +: AXIS_W]});
        eng_result = res;
        eng_done   = 1'b1;
        @(posedge axi_aclk); #1;
        eng_done   = 1'b0;
        chk("fb_valid_after_done", 64'(fb_valid), 64'(!last));
        chk("busy_after_done", 64'(busy), 64'(last));
        if (!last) begin
            n_cmp++;
            assert (fb_data === exp) else begin
                n_err++;
                $error("FAIL fb_data: observed low %h expected low %h", fb_data[63:0], exp[63:0]);
            end
        end
    endtask

    task automatic wait_send(input bit toggle);
        int n;
        n = 0;
        while ((busy || m_exp_q.size() != 0) && n < 2000) begin
            @(posedge axi_aclk); #1;
            if (toggle) m_axis.tready = ~m_axis.tready;
            n++;
        end
        chk("send_done_busy", 64'(busy), 64'd0);
        chk("send_all_beats", 64'(m_exp_q.size()), 64'd0);
        m_axis.tready = 1'b1;
    endtask

    initial begin
        s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        m_axis.tready = 1'b1;
        res1  = make_res(11, 1'b1);
        res3  = make_res(5, 1'b0);
        res3[15:0]  = 16'hBC00;
        res3[31:16] = 16'h3C00;
        res3[95:80] = 16'h8000;
        exp3 = res3;
`ifdef NDP_STREAM_RELU_EN
        exp3[15:0]  = 16'h0000;
        exp3[95:80] = 16'h0000;
`endif
        res_a = make_res(99, 1'b1);
        res_b = make_res(7, 1'b0);

        // Reset state
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tready", 64'(s_axis.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("rst_row_valid", 64'(eng_row_valid), 64'd0);
        chk("rst_fb_valid", 64'(fb_valid), 64'd0);
        chk("rst_err", 64'(err_short_row), 64'd0);
        chk("rst_sp_wen", 64'(sp_wen), 64'd0);
        chk("rst_fb_data_low", fb_data[63:0], 64'd0);
        @(posedge axi_aclk); #1;
        axi_aresetn = 1'b1;

        // One full row, last layer, no ReLU: 128 result beats
        start_layer(1'b0, 1'b1);
        send_row(34, 0, 1'b1, 1);
        chk("full_row_no_err", 64'(err_short_row), 64'd0);
        ack_row(1'b1);
        layer_done(res1, res1, 1'b1);
        wait_send(1'b0);

        // Three rows with ack withheld; ReLU on; stalled output stream
        start_layer(1'b1, 1'b1);
        send_row(34, 0, 1'b0, 2);
        send_row(34, 0, 1'b0, 3);
        s_axis.tdata = {16'd4, 16'd0}; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
        sp_exp_q.push_back({tb_wbank, 6'd0, 32'({16'd4, 16'd0})});
        repeat (3) begin
            @(negedge axi_aclk);
            chk("tready_both_full", 64'(s_axis.tready), 64'd0);
        end
        @(posedge axi_aclk); #1;
        chk("row0_valid_held", 64'(eng_row_valid), 64'd1);
        chk("row0_bank", 64'(eng_row_bank), 64'(tb_rbank));
        eng_row_ack = 1'b1;
        tb_rbank = ~tb_rbank;
        @(posedge axi_aclk); #1;
        eng_row_ack = 1'b0;
        @(negedge axi_aclk);
        chk("tready_after_ack", 64'(s_axis.tready), 64'd1);
        @(posedge axi_aclk); #1;
        s_axis.tvalid = 1'b0;
        for (int i = 1; i < 34; i++) push_beat({16'd4, 16'(i)}, i == 33, 6'(i));
        tb_wbank = ~tb_wbank;
        ack_row(1'b0);
        ack_row(1'b1);
        layer_done(res3, exp3, 1'b1);
        wait_send(1'b1);

        // Layer A: not last, short row (tlast on 10th beat)
        start_layer(1'b0, 1'b0);
        send_row(10, 0, 1'b1, 5);
        chk("err_short_row_set", 64'(err_short_row), 64'd1);
        ack_row(1'b1);
        layer_done(res_a, res_a, 1'b0);

        // Layer B: feedback mode, rows start at ACT_BEATS, 32 beats each
        start_layer(1'b0, 1'b1);
        chk("fb_valid_held", 64'(fb_valid), 64'd1);
        n_cmp++;
        assert (fb_data === res_a) else begin
            n_err++;
            $error("FAIL fb_data_layer_a: observed low %h expected low %h", fb_data[63:0], res_a[63:0]);
        end
        send_row(32, 2, 1'b1, 6);
        chk("fb_row_no_err", 64'(err_short_row), 64'd0);
        ack_row(1'b1);
        layer_done(res_b, res_b, 1'b1);

        // Reset in the middle of SEND
        begin
            int n;
            n = 0;
            while (m_exp_q.size() > 88 && n < 1000) begin
                @(posedge axi_aclk); #1;
                n++;
            end
            chk("send_progress", 64'(m_exp_q.size() <= 88), 64'd1);
        end
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        chk("midsend_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("midsend_rst_busy", 64'(busy), 64'd0);
        chk("midsend_rst_fb_valid", 64'(fb_valid), 64'd0);
        chk("midsend_rst_row_valid", 64'(eng_row_valid), 64'd0);
        m_exp_q.delete();
        @(posedge axi_aclk); #1;
        axi_aresetn = 1'b1;
        tb_wbank = 1'b0;
        tb_rbank = 1'b0;

        // Back in IDLE: a new layer is accepted and writes from bank 0, address 0
        start_layer(1'b0, 1'b0);
        push_beat(32'hA5A5_0001, 1'b0, 6'd0);
        chk("sp_queue_drained", 64'(sp_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule
